// File: rtl/decode_queue_pkg.sv
// decode_pkg: shared definitions for the decode stage.
//   - MIPS opcode constants used by the field decoder
//   - uop_t: issue-ready micro-op as stored in the decode queue
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  addra;
    logic [4:0]  addrb;
    logic [4:0]  regdest;
    logic        selregdest;
    logic [31:0] imedext;
    logic [31:0] nextpc;
  } uop_t;

endpackage

// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch-side and issue-side handshake bundle of the decode queue.
//   Fetch:  if_id_valid, if_id_instruc, if_id_nextpc -> queue; id_if_ready <- queue
//   Issue:  id_iss_valid + payload, id_count <- queue; iss_id_ready -> queue
//   flush:  redirect, discards all buffered micro-ops
// Modports: slave = the queue, master = the surrounding pipeline.
interface decode_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             if_id_valid;
  logic [31:0]      if_id_instruc;
  logic [31:0]      if_id_nextpc;
  logic             id_if_ready;
  logic             flush;
  logic             id_iss_valid;
  logic             iss_id_ready;
  logic [5:0]       id_iss_op;
  logic [5:0]       id_iss_funct;
  logic [4:0]       id_iss_addra;
  logic [4:0]       id_iss_addrb;
  logic [4:0]       id_iss_regdest;
  logic             id_iss_selregdest;
  logic [31:0]      id_iss_imedext;
  logic [31:0]      id_iss_nextpc;
  logic [CNT_W-1:0] id_count;

  modport slave (
    input  if_id_valid, if_id_instruc, if_id_nextpc, flush, iss_id_ready,
    output id_if_ready, id_iss_valid, id_iss_op, id_iss_funct, id_iss_addra,
           id_iss_addrb, id_iss_regdest, id_iss_selregdest, id_iss_imedext,
           id_iss_nextpc, id_count
  );

  modport master (
    output if_id_valid, if_id_instruc, if_id_nextpc, flush, iss_id_ready,
    input  id_if_ready, id_iss_valid, id_iss_op, id_iss_funct, id_iss_addra,
           id_iss_addrb, id_iss_regdest, id_iss_selregdest, id_iss_imedext,
           id_iss_nextpc, id_count
  );

endinterface

// File: rtl/decode_queue_uop_field_decode.sv
// uop_field_decode: combinational MIPS field decode into a uop_t.
//   instruc  in  32  instruction word
//   nextpc   in  32  PC+4, carried through unchanged
//   uop      out     decoded micro-op
// ZEXT_LOGIC selects zero extension for ANDI/ORI/XORI immediates.
module uop_field_decode
  import decode_pkg::*;
#(
  parameter bit ZEXT_LOGIC = 1'b1
) (
  input  logic [31:0] instruc,
  input  logic [31:0] nextpc,
  output uop_t        uop
);

  logic [5:0] op;
  logic       is_logic_imm;

  assign op = instruc[31:26];
  assign is_logic_imm = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);

  always_comb begin
    uop            = '0;
    uop.op         = op;
    uop.funct      = instruc[5:0];
    uop.addra      = instruc[25:21];
    uop.addrb      = instruc[20:16];
    uop.selregdest = (op == OP_RTYPE);
    uop.regdest    = (op == OP_RTYPE) ? instruc[15:11] : instruc[20:16];
    uop.imedext    = (ZEXT_LOGIC && is_logic_imm) ? {16'b0, instruc[15:0]}
                                                  : {{16{instruc[15]}}, instruc[15:0]};
    uop.nextpc     = nextpc;
  end

endmodule

// File: rtl/decode_queue.sv
// decode_queue: decode stage between fetch and issue.
//   clock  in   pipeline clock, rising edge
//   reset  in   asynchronous, active-low
//   bus    slave modport of decode_queue_if (fetch handshake, issue
//          handshake + decoded payload, flush, occupancy)
// Each accepted instruction is decoded on the way in and buffered in a
// DEPTH-entry FIFO; the head entry drives the issue payload.
module decode_queue
  import decode_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter bit ZEXT_LOGIC = 1'b1,
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic            clock,
  input  logic            reset,
  decode_queue_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  uop_t             mem [DEPTH];

  uop_t dec_uop;
  uop_t head_uop;
  logic full;
  logic empty;
  logic push;
  logic pop;

  uop_field_decode #(
    .ZEXT_LOGIC(ZEXT_LOGIC)
  ) u_decode (
    .instruc (bus.if_id_instruc),
    .nextpc  (bus.if_id_nextpc),
    .uop     (dec_uop)
  );

  // Handshake flags depend only on registered count, so there is no
  // combinational path from iss_id_ready back to id_if_ready.
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.if_id_valid && !full && !bus.flush;
  assign pop   = bus.iss_id_ready && !empty && !bus.flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Payload storage carries no reset; only pointers and count do.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= dec_uop;
  end

  assign head_uop = empty ? '0 : mem[rd_ptr];

  assign bus.id_if_ready       = !full;
  assign bus.id_iss_valid      = !empty;
  assign bus.id_count          = count;
  assign bus.id_iss_op         = head_uop.op;
  assign bus.id_iss_funct      = head_uop.funct;
  assign bus.id_iss_addra      = head_uop.addra;
  assign bus.id_iss_addrb      = head_uop.addrb;
  assign bus.id_iss_regdest    = head_uop.regdest;
  assign bus.id_iss_selregdest = head_uop.selregdest;
  assign bus.id_iss_imedext    = head_uop.imedext;
  assign bus.id_iss_nextpc     = head_uop.nextpc;

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: randomized self-checking bench for decode_queue.
// Two instances share all inputs: dut (ZEXT_LOGIC=1) and dut0 (ZEXT_LOGIC=0).
// A queue of accepted {instruction, nextpc} pairs is the reference; expected
// payloads are decoded from the MIPS field rules.
module tb_decode_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OBS_W = 2 * (1 + 1 + CNT_W + 92);

  logic clock;
  logic reset;

  decode_queue_if #(.DEPTH(DEPTH)) bus ();
  decode_queue_if #(.DEPTH(DEPTH)) bus0 ();

  decode_queue #(.DEPTH(DEPTH), .ZEXT_LOGIC(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  decode_queue #(.DEPTH(DEPTH), .ZEXT_LOGIC(1'b0)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  assign bus0.if_id_valid   = bus.if_id_valid;
  assign bus0.if_id_instruc = bus.if_id_instruc;
  assign bus0.if_id_nextpc  = bus.if_id_nextpc;
  assign bus0.flush         = bus.flush;
  assign bus0.iss_id_ready  = bus.iss_id_ready;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  logic [63:0] mq[$];   // {instruction, nextpc} of buffered entries, oldest first

  // Expected micro-op of one instruction as a flat {op,funct,ra,rb,rd,sel,imm,pc}.
  function automatic logic [91:0] model_uop(input logic [31:0] i, input logic [31:0] pc,
                                            input bit zext);
    logic [5:0]  op;
    logic [31:0] imm;
    logic [4:0]  rd;
    op  = i[31:26];
    imm = (zext && (op == 6'h0C || op == 6'h0D || op == 6'h0E)) ? {16'h0000, i[15:0]}
                                                                 : {{16{i[15]}}, i[15:0]};
    rd  = (op == 6'h00) ? i[15:11] : i[20:16];
    return {op, i[5:0], i[25:21], i[20:16], rd, (op == 6'h00), imm, pc};
  endfunction

  function automatic logic [OBS_W-1:0] expected();
    logic [63:0]       h;
    logic              v;
    logic [91:0]       u1;
    logic [91:0]       u0;
    logic [CNT_W-1:0]  c;
    v  = (mq.size() != 0);
    h  = v ? mq[0] : 64'h0;
    u1 = v ? model_uop(h[63:32], h[31:0], 1'b1) : 92'h0;
    u0 = v ? model_uop(h[63:32], h[31:0], 1'b0) : 92'h0;
    c  = CNT_W'(mq.size());
    return {v, (mq.size() != DEPTH), c, u1, v, (mq.size() != DEPTH), c, u0};
  endfunction

  function automatic logic [OBS_W-1:0] observed();
    return {bus.id_iss_valid, bus.id_if_ready, bus.id_count, bus.id_iss_op, bus.id_iss_funct,
            bus.id_iss_addra, bus.id_iss_addrb, bus.id_iss_regdest, bus.id_iss_selregdest,
            bus.id_iss_imedext, bus.id_iss_nextpc,
            bus0.id_iss_valid, bus0.id_if_ready, bus0.id_count, bus0.id_iss_op,
            bus0.id_iss_funct, bus0.id_iss_addra, bus0.id_iss_addrb, bus0.id_iss_regdest,
            bus0.id_iss_selregdest, bus0.id_iss_imedext, bus0.id_iss_nextpc};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: r[31:26] = 6'h00;
      1: r[31:26] = 6'h0C;
      2: r[31:26] = 6'h0D;
      3: r[31:26] = 6'h0E;
      default: ;
    endcase
    return r;
  endfunction

  // One clock edge: update the reference from the inputs seen at the edge,
  // then move #1 past the edge so outputs can be sampled.
  task automatic step();
    bit push;
    bit pop;
    @(posedge clock);
    push = bus.if_id_valid && (mq.size() != DEPTH) && !bus.flush;
    pop  = bus.iss_id_ready && (mq.size() != 0) && !bus.flush;
    if (bus.flush) mq.delete();
    else begin
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back({bus.if_id_instruc, bus.if_id_nextpc});
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit rdy, input bit fl);
    bus.if_id_valid   = v;
    bus.if_id_instruc = ins;
    bus.if_id_nextpc  = pc;
    bus.iss_id_ready  = rdy;
    bus.flush         = fl;
  endtask

  task automatic drain();
    for (int unsigned n = 0; n < 2 * DEPTH && mq.size() != 0; n++) begin
      drive(1'b0, $urandom, $urandom, 1'b1, 1'b0);
      step();
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    #3;
    mq.delete();
    checks++;
    if (observed() !== expected()) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", observed(), expected());
    end
    #14 reset = 1'b1;
    step();
  endtask

  task automatic test_single_add();
    logic [92:0] want;
    logic [92:0] got;
    drive(1'b1, 32'h012A4020, 32'h00400004, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
    want = {1'b1, 6'h00, 6'h20, 5'd9, 5'd10, 5'd8, 1'b1, 32'h00004020, 32'h00400004};
    got  = {bus.id_iss_valid, bus.id_iss_op, bus.id_iss_funct, bus.id_iss_addra,
            bus.id_iss_addrb, bus.id_iss_regdest, bus.id_iss_selregdest,
            bus.id_iss_imedext, bus.id_iss_nextpc};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL add_fields: got %h want %h", got, want);
    end
    checks++;
    if (observed() !== expected()) begin
      errors++;
      $display("FAIL add_model: got %h want %h", observed(), expected());
    end
    drain();
  endtask

  task automatic test_ori_ext();
    logic [75:0] want;
    logic [75:0] got;
    drive(1'b1, 32'h3508FFFF, 32'h00400010, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    want = {32'h0000FFFF, 32'hFFFFFFFF, 5'd8, 1'b0, 5'd8, 1'b0};
    got  = {bus.id_iss_imedext, bus0.id_iss_imedext, bus.id_iss_regdest,
            bus.id_iss_selregdest, bus0.id_iss_regdest, bus0.id_iss_selregdest};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL ori_ext: got %h want %h", got, want);
    end
    drain();
  endtask

  task automatic test_fill();
    logic [CNT_W:0] flags;
    for (int unsigned n = 0; n < DEPTH + 1; n++) begin
      drive(1'b1, rand_instr(), $urandom, 1'b0, 1'b0);
      step();
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL fill_%0d: got %h want %h", n, observed(), expected());
      end
    end
    flags = {bus.id_if_ready, bus.id_count};
    checks++;
    if (flags !== {1'b0, CNT_W'(DEPTH)}) begin
      errors++;
      $display("FAIL full_flags: got %h want %h", flags, {1'b0, CNT_W'(DEPTH)});
    end
    for (int unsigned n = 0; n < DEPTH; n++) begin
      drive(1'b0, $urandom, $urandom, 1'b1, 1'b0);
      step();
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL fill_pop_%0d: got %h want %h", n, observed(), expected());
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int unsigned n = 0; n < 2; n++) begin
      drive(1'b1, rand_instr(), $urandom, 1'b0, 1'b0);
      step();
    end
    for (int unsigned n = 0; n < 10; n++) begin
      drive(1'b1, rand_instr(), $urandom, 1'b1, 1'b0);
      step();
      checks++;
      if (observed() !== expected() || bus.id_count !== CNT_W'(2)) begin
        errors++;
        $display("FAIL b2b_%0d: got %h want %h", n, observed(), expected());
      end
    end
    drain();
  endtask

  task automatic test_flush();
    logic [93:0] got;
    for (int unsigned n = 0; n < 3; n++) begin
      drive(1'b1, rand_instr(), $urandom, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'h2108BEEF, 32'h00401000, 1'b1, 1'b1);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    got = {bus.id_iss_valid, bus.id_count == '0, bus.id_iss_op, bus.id_iss_funct,
           bus.id_iss_addra, bus.id_iss_addrb, bus.id_iss_regdest, bus.id_iss_selregdest,
           bus.id_iss_imedext, bus.id_iss_nextpc};
    checks++;
    if (got !== {1'b0, 1'b1, 92'h0}) begin
      errors++;
      $display("FAIL flush_empty: got %h want %h", got, {1'b0, 1'b1, 92'h0});
    end
    step();
    checks++;
    if (observed() !== expected()) begin
      errors++;
      $display("FAIL flush_after: got %h want %h", observed(), expected());
    end
  endtask

  task automatic test_random();
    for (int unsigned n = 0; n < 300; n++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 19) == 0);
      step();
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL random_%0d: got %h want %h", n, observed(), expected());
      end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_async_reset();
    for (int unsigned n = 0; n < 3; n++) begin
      drive(1'b1, rand_instr(), $urandom, 1'b0, 1'b0);
      step();
    end
    checks++;
    if (bus.id_count !== CNT_W'(3)) begin
      errors++;
      $display("FAIL pre_reset_count: got %0d want 3", bus.id_count);
    end
    drive(1'b1, rand_instr(), $urandom, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1;
    mq.delete();
    checks++;
    if (observed() !== expected()) begin
      errors++;
      $display("FAIL async_reset: got %h want %h", observed(), expected());
    end
    @(posedge clock);
    #1;
    checks++;
    if (observed() !== expected()) begin
      errors++;
      $display("FAIL reset_hold: got %h want %h", observed(), expected());
    end
    #3 reset = 1'b1;
    drive(1'b1, 32'h3C01ABCD, 32'h00400100, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (observed() !== expected() || bus.id_iss_valid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_push: got %h want %h", observed(), expected());
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_ori_ext();
    test_fill();
    test_back_to_back();
    test_flush();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
